// File: rtl/ntt_pkg.sv
// Shared constants, FSM state type and modulus table for the NTT datapath.
// Every block that touches coefficients imports this package.
package ntt_pkg;

   localparam int COEFF_W     = 30;
   localparam int BF_LATENCY  = 10;
   localparam int MEM_LATENCY = 1;
   localparam int TAG_DEPTH   = BF_LATENCY + MEM_LATENCY;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_DONE
   } gs_state_e;

   // Moduli selectable per instance; index 0 is the default 30-bit prime.
   function automatic logic [COEFF_W-1:0] modulus(input int idx);
      case (idx)
         1:       return 30'd998244353;
         2:       return 30'd469762049;
         default: return 30'd1073479681;
      endcase
   endfunction

endpackage

// File: rtl/gs_butterfly.sv
// Pipelined Gentleman-Sande butterfly: x = (a+b) mod q, y = (a-b)*w mod q.
// Fixed latency of BF_LATENCY cycles from a/b/w to x/y.
module gs_butterfly
   import ntt_pkg::*;
#(
   parameter int MOD_INDEX = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [COEFF_W-1:0] a,
   input  logic [COEFF_W-1:0] b,
   input  logic [COEFF_W-1:0] w,
   output logic [COEFF_W-1:0] x,
   output logic [COEFF_W-1:0] y
);

   localparam logic [COEFF_W-1:0] Q = modulus(MOD_INDEX);
   localparam int PROD_W = 2 * COEFF_W;
   localparam int DLY    = BF_LATENCY - 2;

   typedef struct packed {
      logic [COEFF_W-1:0] x;
      logic [COEFF_W-1:0] y;
   } pair_t;

   logic [COEFF_W:0]   sum_wide;
   logic [COEFF_W-1:0] sum1_d, sum1_q, diff1_d, diff1_q, w1_d, w1_q, sum2_d, sum2_q;
   logic [PROD_W-1:0]  prod2_d, prod2_q;
   pair_t              dly_d [DLY];
   pair_t              dly_q [DLY];

   always_comb begin
      // NOTE: every signal gets a value before any branch, so no latch can be inferred.
      sum_wide = {1'b0, a} + {1'b0, b};
      sum1_d   = (sum_wide >= {1'b0, Q}) ? COEFF_W'(sum_wide - {1'b0, Q})
                                         : sum_wide[COEFF_W-1:0];
      diff1_d  = (a >= b) ? (a - b) : (a + (Q - b));
      w1_d     = w;
      sum2_d   = sum1_q;
      prod2_d  = PROD_W'(diff1_q) * PROD_W'(w1_q);
      dly_d[0] = '{x: sum2_q, y: COEFF_W'(prod2_q % PROD_W'(Q))};
      for (int i = 1; i < DLY; i++) dly_d[i] = dly_q[i-1];
   end

   // NOTE: the data pipeline is reset so the outputs read as zero after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum1_q  <= '0;
         diff1_q <= '0;
         w1_q    <= '0;
         sum2_q  <= '0;
         prod2_q <= '0;
         for (int i = 0; i < DLY; i++) dly_q[i] <= '0;
      end else begin
         // NOTE: non-blocking so every stage samples its predecessor's old value.
         sum1_q  <= sum1_d;
         diff1_q <= diff1_d;
         w1_q    <= w1_d;
         sum2_q  <= sum2_d;
         prod2_q <= prod2_d;
         dly_q   <= dly_d;
      end
   end

   assign x = dly_q[DLY-1].x;
   assign y = dly_q[DLY-1].y;

endmodule

// File: rtl/gs_stage_ctrl.sv
// Runs one Gentleman-Sande inverse-NTT stage: issues N/2 butterflies, one per
// cycle, and writes each result pair back in place after the pipeline delay.
module gs_stage_ctrl
   import ntt_pkg::*;
#(
   parameter int LOG_N     = 8,
   parameter int MOD_INDEX = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [3:0]         stage,
   output logic               rd_en,
   output logic [LOG_N-1:0]   rd_addr_a,
   output logic [LOG_N-1:0]   rd_addr_b,
   output logic [LOG_N-1:0]   tw_addr,
   input  logic [COEFF_W-1:0] rd_data_a,
   input  logic [COEFF_W-1:0] rd_data_b,
   input  logic [COEFF_W-1:0] tw_data,
   output logic               wr_en,
   output logic [LOG_N-1:0]   wr_addr_a,
   output logic [LOG_N-1:0]   wr_addr_b,
   output logic [COEFF_W-1:0] wr_data_a,
   output logic [COEFF_W-1:0] wr_data_b,
   output logic               busy,
   output logic               done
);

   localparam int               HALF_N = 1 << (LOG_N - 1);
   localparam logic [LOG_N-1:0] J_LAST = LOG_N'(HALF_N - 1);
   localparam logic [LOG_N:0]   N_FULL = (LOG_N + 1)'(1) << LOG_N;

   typedef struct packed {
      logic             valid;
      logic [LOG_N-1:0] addr_a;
      logic [LOG_N-1:0] addr_b;
   } tag_t;

   gs_state_e        state_d, state_q;
   logic [3:0]       stage_d, stage_q;
   logic [LOG_N-1:0] j_d, j_q;
   tag_t             tag_d [TAG_DEPTH];
   tag_t             tag_q [TAG_DEPTH];
   logic             issue;
   logic             tag_pending;
   logic [4:0]       grp_shift;
   logic [LOG_N-1:0] span, grp, ofs, addr_a, addr_b, tw;

   // j splits into group g (upper bits) and offset k (lower s bits).
   always_comb begin
      grp_shift = {1'b0, stage_q} + 5'd1;
      span      = LOG_N'(1) << stage_q;
      grp       = j_q >> stage_q;
      ofs       = j_q & (span - LOG_N'(1));
      addr_a    = (grp << grp_shift) + ofs;
      addr_b    = addr_a + span;
      tw        = LOG_N'((N_FULL >> grp_shift) + (LOG_N + 1)'(grp));
   end

   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      j_d     = j_q;
      issue   = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start && (int'(stage) < LOG_N)) begin
               stage_d = stage;
               j_d     = '0;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            issue = 1'b1;
            j_d   = j_q + LOG_N'(1);
            if (j_q == J_LAST) begin
               j_d     = '0;
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!tag_pending) state_d = ST_DONE;
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign rd_en     = issue;
   assign rd_addr_a = issue ? addr_a : '0;
   assign rd_addr_b = issue ? addr_b : '0;
   assign tw_addr   = issue ? tw     : '0;
   assign busy      = (state_q != ST_IDLE);

   // Pending looks at the next contents, so DONE follows the last write directly.
   always_comb begin
      tag_d[0]    = '{valid: issue, addr_a: rd_addr_a, addr_b: rd_addr_b};
      for (int i = 1; i < TAG_DEPTH; i++) tag_d[i] = tag_q[i-1];
      tag_pending = 1'b0;
      for (int i = 0; i < TAG_DEPTH; i++) tag_pending = tag_pending | tag_d[i].valid;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         stage_q <= '0;
         j_q     <= '0;
         for (int i = 0; i < TAG_DEPTH; i++) tag_q[i] <= '0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         j_q     <= j_d;
         tag_q   <= tag_d;
      end
   end

   assign wr_en     = tag_q[TAG_DEPTH-1].valid;
   assign wr_addr_a = tag_q[TAG_DEPTH-1].addr_a;
   assign wr_addr_b = tag_q[TAG_DEPTH-1].addr_b;

   gs_butterfly #(
      .MOD_INDEX(MOD_INDEX)
   ) u_butterfly (
      .clk(clk),
      .rst(rst),
      .a  (rd_data_a),
      .b  (rd_data_b),
      .w  (tw_data),
      .x  (wr_data_a),
      .y  (wr_data_b)
   );

endmodule

// File: tb/tb_gs_stage_ctrl.sv
// Bench for gs_stage_ctrl: a memory model answers reads one cycle later and a
// scoreboard predicts every write-back (address, data, cycle).
`timescale 1ns/1ps
module tb_gs_stage_ctrl;

   localparam int              LOG_N = 8;
   localparam longint unsigned Q     = 64'd1073479681;
   localparam int              RD_TO_WR = 11;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  stage = 4'd0;
   logic        rd_en;
   logic [7:0]  rd_addr_a, rd_addr_b, tw_addr;
   logic [29:0] rd_data_a = '0;
   logic [29:0] rd_data_b = '0;
   logic [29:0] tw_data   = '0;
   logic        wr_en;
   logic [7:0]  wr_addr_a, wr_addr_b;
   logic [29:0] wr_data_a, wr_data_b;
   logic        busy, done;

   gs_stage_ctrl #(.LOG_N(LOG_N), .MOD_INDEX(0)) dut (
      .clk(clk), .rst(rst), .start(start), .stage(stage),
      .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .tw_data(tw_data),
      .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
      .wr_data_a(wr_data_a), .wr_data_b(wr_data_b),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int              addr_a;
      int              addr_b;
      longint unsigned da;
      longint unsigned db;
      int              due;
   } sb_t;

   sb_t sb_q[$];

   int chk_cnt = 0, pass_cnt = 0, fail_cnt = 0;
   int mon_stage = 0, data_mode = 0, mon_j = 0;
   int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, busy_cnt = 0;
   int first_rd_cyc = 0, last_rd_cyc = 0, done_cyc = 0, start_cyc = 0;
   bit prev_rd = 0, busy_at_done = 0;
   int log_a[128], log_b[128], log_tw[128];
   logic [29:0] last_wr_a = '0, last_wr_b = '0;

   task automatic run_monitor();
      sb_t e;
      bit pend_v = 0;
      logic [29:0] pa = '0, pb = '0, pw = '0;
      int s, d, g, k, ea, eb, et;
      longint unsigned va, vb, vw;
      forever begin
         @(negedge clk);
         if (rst) begin
            sb_q.delete();
            pend_v = 0; prev_rd = 0;
            rd_data_a = '0; rd_data_b = '0; tw_data = '0;
            continue;
         end
         rd_data_a = pend_v ? pa : '0;
         rd_data_b = pend_v ? pb : '0;
         tw_data   = pend_v ? pw : '0;
         pend_v = 0;
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++; done_cyc = cyc; busy_at_done = busy;
         end
         if (rd_en) begin
            if (!prev_rd) begin
               mon_j = 0; first_rd_cyc = cyc;
            end
            s = mon_stage; d = 1 << s; g = mon_j >> s; k = mon_j & (d - 1);
            ea = 2 * d * g + k; eb = ea + d; et = (256 >> (s + 1)) + g;
            chk_cnt++;
            if ({rd_addr_a, rd_addr_b, tw_addr} !== {8'(ea), 8'(eb), 8'(et)}) begin
               fail_cnt++;
               $display("FAIL rd_addr j=%0d s=%0d: got %0d/%0d/%0d, want %0d/%0d/%0d",
                        mon_j, s, rd_addr_a, rd_addr_b, tw_addr, ea, eb, et);
            end else pass_cnt++;
            if (mon_j < 128) begin
               log_a[mon_j] = int'(rd_addr_a); log_b[mon_j] = int'(rd_addr_b);
               log_tw[mon_j] = int'(tw_addr);
            end
            case (data_mode)
               1:       begin va = 5; vb = 3; vw = 2; end
               2:       begin va = 0; vb = 1; vw = 1; end
               default: begin
                  va = (longint'(ea) * 1000003 + 17) % Q;
                  vb = (longint'(eb) * 1000003 + 17) % Q;
                  vw = (longint'(et) * 7777 + 3) % Q;
               end
            endcase
            pa = 30'(va); pb = 30'(vb); pw = 30'(vw); pend_v = 1;
            e.addr_a = ea; e.addr_b = eb;
            e.da = (va + vb) % Q;
            e.db = (((va + Q - vb) % Q) * vw) % Q;
            e.due = cyc + RD_TO_WR;
            sb_q.push_back(e);
            mon_j++; rd_cnt++; last_rd_cyc = cyc;
         end
         prev_rd = rd_en;
         if (wr_en) begin
            wr_cnt++; last_wr_a = wr_data_a; last_wr_b = wr_data_b;
            chk_cnt++;
            if (sb_q.size() == 0) begin
               fail_cnt++;
               $display("FAIL wr_unexpected: got write at cycle %0d, want none", cyc);
            end else begin
               pass_cnt++;
               e = sb_q.pop_front();
               chk_cnt++;
               if ({wr_addr_a, wr_addr_b} !== {8'(e.addr_a), 8'(e.addr_b)}) begin
                  fail_cnt++;
                  $display("FAIL wr_addr: got %0d/%0d, want %0d/%0d",
                           wr_addr_a, wr_addr_b, e.addr_a, e.addr_b);
               end else pass_cnt++;
               chk_cnt++;
               if ({wr_data_a, wr_data_b} !== {30'(e.da), 30'(e.db)}) begin
                  fail_cnt++;
                  $display("FAIL wr_data: got %0d/%0d, want %0d/%0d",
                           wr_data_a, wr_data_b, e.da, e.db);
               end else pass_cnt++;
               chk_cnt++;
               if (cyc !== e.due) begin
                  fail_cnt++;
                  $display("FAIL wr_latency: got cycle %0d, want %0d", cyc, e.due);
               end else pass_cnt++;
            end
         end
      end
   endtask

   task automatic start_stage(input int s, input bit model);
      @(negedge clk);
      stage = 4'(s);
      if (model) mon_stage = s;
      start = 1'b1;
      start_cyc = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int snap, output bit ok);
      ok = 0;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk);
         if (done_cnt > snap) ok = 1;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      chk_cnt++;
      if ({rd_en, rd_addr_a, rd_addr_b, tw_addr, wr_en, wr_addr_a, wr_addr_b,
           wr_data_a, wr_data_b, busy, done} !== '0) begin
         fail_cnt++; $display("FAIL reset_outputs: got nonzero, want all 0");
      end else pass_cnt++;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk_cnt++;
      if ({rd_en, wr_en, busy, done, rd_addr_a, rd_addr_b, tw_addr} !== '0) begin
         fail_cnt++; $display("FAIL idle_outputs: got nonzero, want all 0");
      end else pass_cnt++;
   endtask

   task automatic test_stage0();
      int c0, rd0, wr0; bit ok;
      data_mode = 0; rd0 = rd_cnt; wr0 = wr_cnt;
      start_stage(0, 1); c0 = start_cyc;
      wait_done(done_cnt, ok);
      chk_cnt++;
      if (!ok) begin fail_cnt++; $display("FAIL s0_timeout: got no done, want done"); end
      else pass_cnt++;
      chk_cnt++;
      if (done_cyc !== c0 + 140) begin
         fail_cnt++; $display("FAIL s0_done_cycle: got %0d, want %0d", done_cyc - c0, 140);
      end else pass_cnt++;
      chk_cnt++;
      if (busy_at_done !== 1'b1) begin
         fail_cnt++; $display("FAIL s0_busy_at_done: got %0b, want 1", busy_at_done);
      end else pass_cnt++;
      chk_cnt++;
      if ({first_rd_cyc - c0, last_rd_cyc - c0, rd_cnt - rd0} !== {32'd1, 32'd128, 32'd128}) begin
         fail_cnt++;
         $display("FAIL s0_rd_window: got first=%0d last=%0d n=%0d, want 1/128/128",
                  first_rd_cyc - c0, last_rd_cyc - c0, rd_cnt - rd0);
      end else pass_cnt++;
      chk_cnt++;
      if ({log_a[0], log_b[0], log_tw[0]} !== {32'd0, 32'd1, 32'd128}) begin
         fail_cnt++;
         $display("FAIL s0_issue0: got %0d/%0d/%0d, want 0/1/128", log_a[0], log_b[0], log_tw[0]);
      end else pass_cnt++;
      chk_cnt++;
      if ({log_a[127], log_b[127], log_tw[127]} !== {32'd254, 32'd255, 32'd255}) begin
         fail_cnt++;
         $display("FAIL s0_issue127: got %0d/%0d/%0d, want 254/255/255",
                  log_a[127], log_b[127], log_tw[127]);
      end else pass_cnt++;
      chk_cnt++;
      if (wr_cnt - wr0 !== 128) begin
         fail_cnt++; $display("FAIL s0_writes: got %0d, want 128", wr_cnt - wr0);
      end else pass_cnt++;
      while (cyc <= done_cyc) @(negedge clk);
      chk_cnt++;
      if ({busy, done} !== 2'b00) begin
         fail_cnt++; $display("FAIL s0_after_done: got busy/done %0b%0b, want 00", busy, done);
      end else pass_cnt++;
   endtask

   task automatic test_stage7();
      int c0; bit ok;
      data_mode = 0;
      start_stage(7, 1); c0 = start_cyc;
      wait_done(done_cnt, ok);
      chk_cnt++;
      if (!ok || done_cyc !== c0 + 140) begin
         fail_cnt++; $display("FAIL s7_done: got ok=%0b cycle %0d, want 1 cycle 140", ok, done_cyc - c0);
      end else pass_cnt++;
      chk_cnt++;
      if ({log_a[0], log_b[0], log_tw[0]} !== {32'd0, 32'd128, 32'd1}) begin
         fail_cnt++;
         $display("FAIL s7_issue0: got %0d/%0d/%0d, want 0/128/1", log_a[0], log_b[0], log_tw[0]);
      end else pass_cnt++;
      chk_cnt++;
      if ({log_a[5], log_b[5], log_tw[5]} !== {32'd5, 32'd133, 32'd1}) begin
         fail_cnt++;
         $display("FAIL s7_issue5: got %0d/%0d/%0d, want 5/133/1", log_a[5], log_b[5], log_tw[5]);
      end else pass_cnt++;
   endtask

   task automatic test_data();
      int wr0; bit ok;
      data_mode = 1; wr0 = wr_cnt;
      start_stage(3, 1);
      wait_done(done_cnt, ok);
      chk_cnt++;
      if (!ok || wr_cnt - wr0 !== 128) begin
         fail_cnt++; $display("FAIL data_writes: got ok=%0b n=%0d, want 1/128", ok, wr_cnt - wr0);
      end else pass_cnt++;
      chk_cnt++;
      if ({last_wr_a, last_wr_b} !== {30'd8, 30'd4}) begin
         fail_cnt++; $display("FAIL data_value: got %0d/%0d, want 8/4", last_wr_a, last_wr_b);
      end else pass_cnt++;
   endtask

   task automatic test_data_wrap();
      bit ok;
      data_mode = 2;
      start_stage(1, 1);
      wait_done(done_cnt, ok);
      chk_cnt++;
      if (!ok || {last_wr_a, last_wr_b} !== {30'd1, 30'(Q - 1)}) begin
         fail_cnt++;
         $display("FAIL data_wrap: got ok=%0b %0d/%0d, want 1 1/%0d", ok, last_wr_a, last_wr_b, Q - 1);
      end else pass_cnt++;
   endtask

   task automatic test_illegal();
      int b0, r0, d0;
      b0 = busy_cnt; r0 = rd_cnt; d0 = done_cnt;
      start_stage(8, 0);
      repeat (20) @(negedge clk);
      chk_cnt++;
      if ({busy_cnt - b0, rd_cnt - r0, done_cnt - d0} !== {32'd0, 32'd0, 32'd0}) begin
         fail_cnt++;
         $display("FAIL illegal_stage: got busy=%0d rd=%0d done=%0d, want 0/0/0",
                  busy_cnt - b0, rd_cnt - r0, done_cnt - d0);
      end else pass_cnt++;
   endtask

   task automatic test_start_during_issue();
      int c0, r0, w0, d0; bit ok;
      data_mode = 0; r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
      start_stage(2, 1); c0 = start_cyc;
      repeat (40) @(negedge clk);
      start_stage(5, 0);
      wait_done(d0, ok);
      chk_cnt++;
      if (!ok || done_cyc !== c0 + 140) begin
         fail_cnt++; $display("FAIL restart_done: got ok=%0b cycle %0d, want 1 cycle 140", ok, done_cyc - c0);
      end else pass_cnt++;
      repeat (30) @(negedge clk);
      chk_cnt++;
      if ({rd_cnt - r0, wr_cnt - w0, done_cnt - d0} !== {32'd128, 32'd128, 32'd1}) begin
         fail_cnt++;
         $display("FAIL restart_counts: got rd=%0d wr=%0d done=%0d, want 128/128/1",
                  rd_cnt - r0, wr_cnt - w0, done_cnt - d0);
      end else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int c0, w0, d0; bit ok;
      data_mode = 0;
      start_stage(0, 1); c0 = start_cyc;
      while (cyc < c0 + 60) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_cnt++;
      if ({rd_en, rd_addr_a, rd_addr_b, tw_addr, wr_en, wr_addr_a, wr_addr_b,
           wr_data_a, wr_data_b, busy, done} !== '0) begin
         fail_cnt++; $display("FAIL midreset_outputs: got nonzero, want all 0");
      end else pass_cnt++;
      w0 = wr_cnt; d0 = done_cnt;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      chk_cnt++;
      if ({wr_cnt - w0, done_cnt - d0, 31'd0, busy} !== '0) begin
         fail_cnt++;
         $display("FAIL midreset_quiet: got wr=%0d done=%0d busy=%0b, want 0/0/0",
                  wr_cnt - w0, done_cnt - d0, busy);
      end else pass_cnt++;
      w0 = wr_cnt;
      start_stage(0, 1); c0 = start_cyc;
      wait_done(done_cnt, ok);
      chk_cnt++;
      if (!ok || done_cyc !== c0 + 140 || wr_cnt - w0 !== 128) begin
         fail_cnt++;
         $display("FAIL midreset_rerun: got ok=%0b cycle %0d wr=%0d, want 1/140/128",
                  ok, done_cyc - c0, wr_cnt - w0);
      end else pass_cnt++;
   endtask

   initial begin
      fork
         run_monitor();
      join_none
      test_reset();
      test_stage0();
      test_stage7();
      test_data();
      test_data_wrap();
      test_illegal();
      test_start_during_issue();
      test_reset_mid();
      repeat (5) @(negedge clk);
      chk_cnt++;
      if (sb_q.size() != 0) begin
         fail_cnt++; $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
      end else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
